// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. One operation is
// accepted at a time through a valid/ready handshake. The operands are held
// in registers that drive the ALU for one cycle. The ALU result and flags are
// then captured and returned on a single response channel, tagged with the
// id of the requester that issued the operation.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake for requester N (0/1)
//   reqN_a, reqN_b                operands (ancho bits)
//   reqN_op                       4-bit ALU control code
//   reqN_flag                     ALU flag-in (operand select / carry-in)
//   resp_valid / resp_ready       response handshake
//   resp_id                       requester that issued the operation
//   resp_result, resp_flags       captured ALU result and flags {N,Z,C,V}
//   alu_a, alu_b, alu_control,    registered drive to the external ALU
//   alu_flagin
//   alu_result, alu_flags         combinational return from the ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int ancho = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ancho-1:0] req0_a,
    input  logic [ancho-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req0_flag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ancho-1:0] req1_a,
    input  logic [ancho-1:0] req1_b,
    input  logic [3:0]       req1_op,
    input  logic             req1_flag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [ancho-1:0] resp_result,
    output logic [3:0]       resp_flags,

    output logic [ancho-1:0] alu_a,
    output logic [ancho-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic             alu_flagin,
    input  logic [ancho-1:0] alu_result,
    input  logic [3:0]       alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;       // id of the requester served most recently
    logic [ancho-1:0] a_q;
    logic [ancho-1:0] b_q;
    logic [3:0]       op_q;
    logic             flag_q;
    logic             id_q;
    logic [ancho-1:0] result_q;
    logic [3:0]       flags_q;
    logic             resp_id_q;

    // Next-state operand values: the granted requester's fields.
    logic             grant_d;
    logic             accept_d;
    logic [ancho-1:0] a_d;
    logic [ancho-1:0] b_d;
    logic [3:0]       op_d;
    logic             flag_d;

    // Round-robin: on contention the requester not served last wins.
    // With a single valid requester grant simply follows it.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
    end

    // Ready is gated by rst so nothing is accepted during the reset cycle,
    // even though the registered state already reads IDLE.
    assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant_d;
    assign req1_ready = (state_q == IDLE) && !rst && req1_valid &&  grant_d;
    assign accept_d   = req0_ready || req1_ready;

    assign a_d    = grant_d ? req1_a    : req0_a;
    assign b_d    = grant_d ? req1_b    : req0_b;
    assign op_d   = grant_d ? req1_op   : req0_op;
    assign flag_d = grant_d ? req1_flag : req0_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            flag_q    <= 1'b0;
            id_q      <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            resp_id_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        op_q    <= op_d;
                        flag_q  <= flag_d;
                        id_q    <= grant_d;
                        last_q  <= grant_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has seen the operand registers for a full
                    // cycle; sample its combinational outputs now.
                    result_q  <= alu_result;
                    flags_q   <= alu_flags;
                    resp_id_q <= id_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ALU drive comes only from registers, so it never follows the
    // request inputs and holds its value outside EXEC.
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign alu_flagin  = flag_q;

    assign resp_valid  = (state_q == RESP);
    assign resp_id     = resp_id_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed steps followed by a randomized phase. A small ALU model answers
// the DUT's ALU port. A reference model tracks the expected grant and the
// expected response content at operation level.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    typedef struct packed {
        logic       v;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       f;
    } req_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_flag;
    logic [3:0] req0_a, req0_b, req0_op;
    logic       req1_valid, req1_ready, req1_flag;
    logic [3:0] req1_a, req1_b, req1_op;
    logic       resp_valid, resp_ready, resp_id;
    logic [3:0] resp_result, resp_flags;
    logic [3:0] alu_a, alu_b, alu_control, alu_result, alu_flags;
    logic       alu_flagin;

    always #5 clk = ~clk;

    alu_arbiter #(.ancho(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_flag(req0_flag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_flag(req1_flag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_flagin(alu_flagin), .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Bench ALU: returns {N,Z,C,V, result}.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op, input logic f);
        logic [4:0] w;
        logic [3:0] r;
        logic       c, v;
        w = 5'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b} + {4'b0, f};
                r = w[3:0]; c = w[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'h1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[3:0]; c = w[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'h2:    r = a & b;
            4'h3:    r = f ? ~b : ~a;
            4'h4:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_control, alu_flagin);

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: operation-level view of the arbiter.
    int         m_phase;     // 0 free, 1 operation in ALU, 2 response offered
    logic       m_last;
    logic [3:0] e_a, e_b, e_op, e_res, e_flags;
    logic       e_f, e_id;
    logic       pend_id;
    logic [7:0] pend_rf;
    logic       acc, acc_id;
    int         grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance one edge,
    // update the model and check the registered outputs.
    task automatic cycle(input logic r, input req_t q0, input req_t q1, input logic rr);
        int   g;
        req_t sel;
        rst        = r;
        req0_valid = q0.v; req0_a = q0.a; req0_b = q0.b; req0_op = q0.op; req0_flag = q0.f;
        req1_valid = q1.v; req1_a = q1.a; req1_b = q1.b; req1_op = q1.op; req1_flag = q1.f;
        resp_ready = rr;
        #1;
        g = -1;
        if (!r && m_phase == 0) begin
            if (q0.v && q1.v)  g = m_last ? 0 : 1;
            else if (q0.v)     g = 0;
            else if (q1.v)     g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        acc    = (g >= 0);
        acc_id = (g == 1);
        sel    = (g == 1) ? q1 : q0;

        @(posedge clk);
        #1;
        if (r) begin
            m_phase = 0; m_last = 1'b1;
            e_a = 0; e_b = 0; e_op = 0; e_f = 0;
            e_id = 0; e_res = 0; e_flags = 0;
        end else if (m_phase == 0) begin
            if (acc) begin
                m_phase = 1; m_last = acc_id;
                e_a = sel.a; e_b = sel.b; e_op = sel.op; e_f = sel.f;
                pend_id = acc_id;
                pend_rf = alu_ref(sel.a, sel.b, sel.op, sel.f);
                grant_log.push_back(g);
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            e_id = pend_id;
            {e_flags, e_res} = pend_rf;
        end else if (rr) begin
            m_phase = 0;
            $display("txn id=%0d result=%h flags=%h t=%0t", e_id, e_res, e_flags, $time);
        end

        chk("resp_valid",  32'(resp_valid),  32'(m_phase == 2));
        chk("alu_a",       32'(alu_a),       32'(e_a));
        chk("alu_b",       32'(alu_b),       32'(e_b));
        chk("alu_control", 32'(alu_control), 32'(e_op));
        chk("alu_flagin",  32'(alu_flagin),  32'(e_f));
        if (m_phase == 2 || r) begin
            chk("resp_id",     32'(resp_id),     32'(e_id));
            chk("resp_result", 32'(resp_result), 32'(e_res));
            chk("resp_flags",  32'(resp_flags),  32'(e_flags));
        end
    endtask

    req_t none, p0, p1, c0, c1;
    int   base;

    initial begin
        m_phase = 0; m_last = 1'b1;
        e_a = 0; e_b = 0; e_op = 0; e_f = 0; e_id = 0; e_res = 0; e_flags = 0;
        pend_id = 0; pend_rf = 0; acc = 0; acc_id = 0;
        none = '0;

        // Reset held with req0 pending: no ready, all outputs zero.
        p0 = '{v:1'b1, a:4'h5, b:4'hA, op:4'h3, f:1'b0};
        cycle(1'b1, p0, none, 1'b0);
        cycle(1'b1, p0, none, 1'b0);

        // First IDLE cycle after release: req0 accepted (NOT a -> 4'hA).
        cycle(1'b0, p0, none, 1'b0);
        cycle(1'b0, none, none, 1'b1);
        chk("single0_exec_a", 32'(alu_a), 32'h5);
        cycle(1'b0, none, none, 1'b1);
        chk("single0_id",     32'(resp_id),     32'h0);
        chk("single0_result", 32'(resp_result), 32'hA);
        cycle(1'b0, none, none, 1'b1);

        // req1, flag=1 selects ~b: b=3 -> 4'hC.
        p1 = '{v:1'b1, a:4'h7, b:4'h3, op:4'h3, f:1'b1};
        cycle(1'b0, none, p1, 1'b0);
        chk("single1_flagin", 32'(alu_flagin), 32'h1);
        cycle(1'b0, none, none, 1'b1);
        chk("single1_id",     32'(resp_id),     32'h1);
        chk("single1_result", 32'(resp_result), 32'hC);
        cycle(1'b0, none, none, 1'b1);

        // Contention: both held valid for four operations.
        c0 = '{v:1'b1, a:4'h1, b:4'h2, op:4'h0, f:1'b0};
        c1 = '{v:1'b1, a:4'h9, b:4'h6, op:4'h1, f:1'b0};
        base = grant_log.size();
        for (int i = 0; i < 12; i++) cycle(1'b0, c0, c1, 1'b1);
        chk("contention_count", 32'(grant_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) chk("contention_order", 32'(grant_log[base + i]), 32'(i % 2));

        // Backpressure: response held for five cycles while req1 waits.
        p0 = '{v:1'b1, a:4'hC, b:4'h5, op:4'h2, f:1'b0};
        cycle(1'b0, p0, none, 1'b0);
        cycle(1'b0, none, c1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, none, c1, 1'b0);
            chk("bp_result_stable", 32'(resp_result), 32'h4);
        end
        cycle(1'b0, none, c1, 1'b1);
        #1;
        chk("bp_next_accept", 32'(req1_ready), 32'h1);
        cycle(1'b0, none, c1, 1'b1);
        cycle(1'b0, none, none, 1'b1);
        cycle(1'b0, none, none, 1'b1);

        // Reset during EXEC after serving req0: operation dropped, last back to 1.
        cycle(1'b0, p0, none, 1'b1);
        cycle(1'b1, c0, c1, 1'b1);
        chk("rst_exec_no_resp", 32'(resp_valid), 32'h0);
        cycle(1'b0, c0, c1, 1'b1);
        chk("rst_exec_grant", 32'(grant_log[grant_log.size() - 1]), 32'h0);
        cycle(1'b0, none, none, 1'b1);
        cycle(1'b0, none, none, 1'b1);

        // Randomized traffic with holds, drops, backpressure and resets.
        p0 = '0; p1 = '0;
        for (int i = 0; i < 400; i++) begin
            logic r, rr;
            if (!p0.v && $urandom_range(2) == 0) begin
                p0.v = 1'b1; p0.a = 4'($urandom); p0.b = 4'($urandom);
                p0.op = 4'($urandom_range(7)); p0.f = 1'($urandom);
            end else if (p0.v && $urandom_range(15) == 0) begin
                p0.v = 1'b0;
            end
            if (!p1.v && $urandom_range(2) == 0) begin
                p1.v = 1'b1; p1.a = 4'($urandom); p1.b = 4'($urandom);
                p1.op = 4'($urandom_range(7)); p1.f = 1'($urandom);
            end else if (p1.v && $urandom_range(15) == 0) begin
                p1.v = 1'b0;
            end
            r  = ($urandom_range(63) == 0);
            rr = 1'($urandom);
            cycle(r, p0, p1, rr);
            if (acc) begin
                if (acc_id) p1.v = 1'b0;
                else        p0.v = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
